spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 The module SHALL declare parameter RD_LAT, default 2, meaning the number of turnaround cycles between the last address bit and the first sampled MISO bit of a read-data frame (range 1..7).
REQ-002 The module SHALL declare parameter GAP_CYC, default 1, meaning the number of SS_n-high cycles after every frame (range 1..7).
REQ-003 The module SHALL have port clk, input, 1 bit: system clock; the same clock drives the attached slave.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The module SHALL have port req_valid, input, 1 bit: a transaction request is present.
REQ-006 The module SHALL have port req_ready, output, 1 bit: a request is accepted this cycle when req_valid and req_ready are both high.
REQ-007 The module SHALL have port req_op, input, 2 bits: opcode, where 00 = write addr, 01 = write data, 10 = read addr, 11 = read data.
REQ-008 The module SHALL have port req_data, input, 8 bits: address or data payload.
REQ-009 The module SHALL have port SS_n, output, 1 bit: active-low slave select.
REQ-010 The module SHALL have port MOSI, output, 1 bit: serial data to the slave.
REQ-011 The module SHALL have port MISO, input, 1 bit: serial data from the slave.
REQ-012 The module SHALL have port rd_valid, output, 1 bit: single-cycle pulse qualifying rd_data.
REQ-013 The module SHALL have port rd_data, output, 8 bits: byte received in a read-data frame.
REQ-014 The module SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, START, CMD, SHIFT, TURN, RECV and GAP; each state's outputs SHALL be register-driven and SHALL hold for every cycle spent in that state.
REQ-016 IDLE behaviour SHALL be: SS_n=1, MOSI=0, req_ready=1; on req_valid, the design SHALL latch frame[9:0]={req_op,req_data} and an op copy, then go to START.
REQ-017 req_ready SHALL be 0 in all non-IDLE states; req_valid outside IDLE SHALL be ignored with no latch and no effect.
REQ-018 START SHALL last 1 cycle with SS_n=0 and MOSI=0, then go to CMD.
REQ-019 CMD SHALL last 1 cycle with SS_n=0 and MOSI=op[1] (0 = write-type, 1 = read-type), then go to SHIFT with bit counter=0.
REQ-020 SHIFT SHALL last exactly 10 cycles with SS_n=0, driving MOSI=frame[9] and shifting frame left each cycle (MSB first: op[1], op[0], data[7..0]).
REQ-021 After the 10th SHIFT cycle, the FSM SHALL go to TURN if op==11; otherwise it SHALL go to GAP.
REQ-022 TURN SHALL last RD_LAT cycles with SS_n=0 and MOSI=0, then go to RECV with counter=0.
REQ-023 RECV SHALL last exactly 8 cycles with SS_n=0 and MOSI=0, sampling MISO each cycle into rx_shift, MSB first (first sample becomes rd_data[7]).
REQ-024 On leaving RECV, the design SHALL load rd_data with the full 8-bit rx_shift and pulse rd_valid=1 for exactly one cycle, coincident with the first GAP cycle.
REQ-025 rd_data SHALL hold its value until the next read-data frame completes.
REQ-026 GAP SHALL last GAP_CYC cycles with SS_n=1 and MOSI=0, then go to IDLE.
REQ-027 The frame length SHALL be: write/read-addr frame = 12 SS_n-low cycles; read-data frame = 20+RD_LAT SS_n-low cycles.
REQ-028 The minimum accept-to-accept spacing SHALL be frame length + GAP_CYC + 1 cycles.
REQ-029 An illegal or unreachable state encoding SHALL recover to IDLE on the next edge with SS_n=1.
REQ-030 The counter SHALL be 4 bits, and SHIFT and RECV counts SHALL never wrap within a frame.

Reset
REQ-031 While rst_n=0 at a clk edge, the design SHALL set state=IDLE, SS_n=1, MOSI=0, rd_valid=0, rd_data=8'h00, busy=0, req_ready=1 (the req_ready value is visible after the edge), and clear counter, frame and rx_shift.
REQ-032 A reset asserted mid-frame SHALL abort the frame: SS_n=1 after the edge, no rd_valid pulse, and no partial rd_data update.

Verification
REQ-033 The bench SHALL cover: write addr req_op=00, req_data=8'hA5 -> SS_n low 12 cycles; MOSI sequence 0,0,0,1,0,1,0,0,1,0,1 (CMD then SHIFT); SS_n=1 for 1 cycle; req_ready=1 after.
REQ-034 The bench SHALL cover: read data req_op=11, req_data=8'h00, slave model drives MISO=8'h3C MSB first starting in cycle RD_LAT+1 after the last SHIFT -> rd_valid pulses once and rd_data=8'h3C.
REQ-035 The bench SHALL cover: back-to-back requests with req_valid held high: op=01 then op=10 -> second accept occurs exactly 14 cycles after the first (GAP_CYC=1); req_valid during the frame is not accepted.
REQ-036 The bench SHALL cover: rst_n=0 during RECV bit 4 of a read-data frame -> SS_n=1, rd_valid never pulses, and rd_data keeps 8'h00.
REQ-037 The bench SHALL cover: RD_LAT=4, GAP_CYC=3, read-data frame -> SS_n low 24 cycles and high 3 cycles; rd_data matches the MISO byte.
REQ-038 The bench SHALL cover: end-to-end with the existing SPI slave plus RAM: write addr 8'h10, write data 8'h5A, read addr 8'h10, read data -> rd_data=8'h5A.

Source files
------------

// File: rtl/spi_master.sv
// SPI master that sends 10-bit {op,data} frames to a slave clocked by the same clk.
// Read-data frames add a turnaround and an 8-bit receive phase before the inter-frame gap.
module spi_master #(
  parameter int RD_LAT  = 2,
  parameter int GAP_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_data,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    CMD   = 3'd2,
    SHIFT = 3'd3,
    TURN  = 3'd4,
    RECV  = 3'd5,
    GAP   = 3'd6
  } state_t;

  localparam logic [3:0] SHIFT_LAST = 4'd9;
  localparam logic [3:0] RECV_LAST  = 4'd7;
  localparam logic [3:0] TURN_LAST  = 4'(RD_LAT - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP_CYC - 1);

  state_t     state, state_n;
  logic [9:0] frame, frame_n;
  logic [1:0] op, op_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] rx_shift, rx_n;
  logic [7:0] rd_data_n;
  logic       rd_valid_n;
  logic       ss_n_n, mosi_n, ready_n, busy_n;

  // Pin outputs are derived from the next state so they are registered
  // alongside it and stay constant for the whole time spent in a state.
  always_comb begin
    state_n    = state;
    frame_n    = frame;
    op_n       = op;
    cnt_n      = cnt;
    rx_n       = rx_shift;
    rd_data_n  = rd_data;
    rd_valid_n = 1'b0;

    case (state)
      IDLE: begin
        if (req_valid) begin
          frame_n = {req_op, req_data};
          op_n    = req_op;
          state_n = START;
        end
      end
      START: state_n = CMD;
      CMD: begin
        cnt_n   = '0;
        state_n = SHIFT;
      end
      SHIFT: begin
        frame_n = {frame[8:0], 1'b0};
        cnt_n   = cnt + 4'd1;
        if (cnt == SHIFT_LAST) begin
          cnt_n   = '0;
          state_n = (op == 2'b11) ? TURN : GAP;
        end
      end
      TURN: begin
        cnt_n = cnt + 4'd1;
        if (cnt == TURN_LAST) begin
          cnt_n   = '0;
          rx_n    = '0;
          state_n = RECV;
        end
      end
      RECV: begin
        rx_n  = {rx_shift[6:0], MISO};
        cnt_n = cnt + 4'd1;
        if (cnt == RECV_LAST) begin
          cnt_n      = '0;
          rd_data_n  = {rx_shift[6:0], MISO};
          rd_valid_n = 1'b1;
          state_n    = GAP;
        end
      end
      GAP: begin
        cnt_n = cnt + 4'd1;
        if (cnt == GAP_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase

    ss_n_n = 1'b1;
    mosi_n = 1'b0;
    case (state_n)
      START, TURN, RECV: ss_n_n = 1'b0;
      CMD: begin
        ss_n_n = 1'b0;
        mosi_n = op_n[1];
      end
      SHIFT: begin
        ss_n_n = 1'b0;
        mosi_n = frame_n[9];
      end
      default: ;
    endcase
    ready_n = (state_n == IDLE);
    busy_n  = (state_n != IDLE);
  end

  // Reset aborts any frame in flight; rd_data is only written on a completed read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      frame     <= '0;
      op        <= '0;
      cnt       <= '0;
      rx_shift  <= '0;
      rd_data   <= 8'h00;
      rd_valid  <= 1'b0;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      frame     <= frame_n;
      op        <= op_n;
      cnt       <= cnt_n;
      rx_shift  <= rx_n;
      rd_data   <= rd_data_n;
      rd_valid  <= rd_valid_n;
      SS_n      <= ss_n_n;
      MOSI      <= mosi_n;
      req_ready <= ready_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (RD_LAT/GAP_CYC 2/1 and 4/3), each with an SPI slave+RAM model,
// a request-level reference model feeding scoreboard queues, and a monitor that checks every frame.
module tb_spi_master;

  typedef struct {
    int          unit;
    int          low_len;
    logic [11:0] mosi;
    logic        is_read;
  } frame_t;

  logic       clk;
  logic       rst_n     [2];
  logic       req_valid [2];
  logic       req_ready [2];
  logic [1:0] req_op    [2];
  logic [7:0] req_data  [2];
  logic       SS_n      [2];
  logic       MOSI      [2];
  logic       MISO      [2];
  logic       rd_valid  [2];
  logic [7:0] rd_data   [2];
  logic       busy      [2];

  int n_checks = 0;
  int n_pass   = 0;
  int cycle    = 0;
  int acc_cnt   [2] = '{0, 0};
  int acc_cycle [2] = '{0, 0};

  frame_t     exp_frames [$];
  logic [7:0] exp_rd     [$];

  logic [7:0] ref_mem   [2][256];
  logic [7:0] ref_addr  [2];
  logic [7:0] ref_raddr [2];

  int         sk      [2];
  logic [9:0] sh      [2];
  logic [7:0] sram    [2][256];
  logic [7:0] s_addr  [2];
  logic [7:0] s_raddr [2];
  logic [7:0] s_byte  [2];

  logic        in_frame [2];
  logic        in_gap   [2];
  int          low_cnt  [2];
  int          gap_cnt  [2];
  logic [11:0] mosi_cap [2];
  logic        extra    [2];
  logic        ctl_bad  [2];
  logic        rv_prev  [2];
  int          rv_cnt   [2];

  spi_master #(.RD_LAT(2), .GAP_CYC(1)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_op(req_op[0]), .req_data(req_data[0]), .SS_n(SS_n[0]), .MOSI(MOSI[0]),
    .MISO(MISO[0]), .rd_valid(rd_valid[0]), .rd_data(rd_data[0]), .busy(busy[0])
  );

  spi_master #(.RD_LAT(4), .GAP_CYC(3)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_op(req_op[1]), .req_data(req_data[1]), .SS_n(SS_n[1]), .MOSI(MOSI[1]),
    .MISO(MISO[1]), .rd_valid(rd_valid[1]), .rd_data(rd_data[1]), .busy(busy[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int rdl(input int u);
    return (u == 0) ? 2 : 4;
  endfunction

  function automatic int gapc(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  always @(posedge clk) begin
    cycle <= cycle + 1;
    for (int u = 0; u < 2; u++) begin
      if (rst_n[u] && req_valid[u] && req_ready[u]) begin
        acc_cnt[u]   <= acc_cnt[u] + 1;
        acc_cycle[u] <= cycle;
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Slave: decodes the 10 shifted bits and serves RAM bytes in the receive window, noise elsewhere.
  task automatic slave_step();
    for (int u = 0; u < 2; u++) begin
      if (SS_n[u] || !rst_n[u]) begin
        sk[u]   = 0;
        MISO[u] = 1'($urandom_range(0, 1));
      end else begin
        int k, j;
        k = sk[u];
        if (k >= 2 && k <= 11) sh[u] = {sh[u][8:0], MOSI[u]};
        if (k == 11) begin
          case (sh[u][9:8])
            2'b00: s_addr[u] = sh[u][7:0];
            2'b01: sram[u][s_addr[u]] = sh[u][7:0];
            2'b10: s_raddr[u] = sh[u][7:0];
            default: s_byte[u] = sram[u][s_raddr[u]];
          endcase
        end
        j = k - (12 + rdl(u));
        if (j >= 0 && j < 8) MISO[u] = s_byte[u][7 - j];
        else MISO[u] = 1'($urandom_range(0, 1));
        sk[u] = k + 1;
      end
    end
  endtask

  task automatic monitor_step();
    for (int u = 0; u < 2; u++) begin
      if (!rst_n[u]) begin
        in_frame[u] = 1'b0;
        in_gap[u]   = 1'b0;
        rv_prev[u]  = 1'b0;
      end else begin
        logic   first_rd_gap;
        frame_t fe;
        first_rd_gap = 1'b0;
        if (!SS_n[u]) begin
          if (!in_frame[u]) begin
            in_frame[u] = 1'b1;
            low_cnt[u]  = 0;
            mosi_cap[u] = '0;
            extra[u]    = 1'b0;
            ctl_bad[u]  = 1'b0;
          end
          if (low_cnt[u] < 12) mosi_cap[u] = {mosi_cap[u][10:0], MOSI[u]};
          else extra[u] = extra[u] | MOSI[u];
          if (req_ready[u] || !busy[u]) ctl_bad[u] = 1'b1;
          low_cnt[u]++;
        end else begin
          if (in_frame[u]) begin
            in_frame[u] = 1'b0;
            check_output("frame_expected", 32'(exp_frames.size() != 0), 1);
            if (exp_frames.size() != 0) begin
              fe = exp_frames.pop_front();
              check_output("frame_unit", u, fe.unit);
              check_output("ss_low_cycles", low_cnt[u], fe.low_len);
              check_output("mosi_bits", mosi_cap[u], fe.mosi);
              check_output("mosi_tail_zero", extra[u], 0);
              check_output("ready_busy_in_frame", ctl_bad[u], 0);
              first_rd_gap = fe.is_read;
            end
            in_gap[u]  = 1'b1;
            gap_cnt[u] = 0;
          end
          if (in_gap[u]) begin
            if (busy[u]) gap_cnt[u]++;
            else begin
              in_gap[u] = 1'b0;
              check_output("gap_cycles", gap_cnt[u], gapc(u));
              check_output("ready_after_gap", req_ready[u], 1);
            end
          end
        end
        if (rd_valid[u] || first_rd_gap) begin
          check_output("rd_valid_at_first_gap", rd_valid[u], first_rd_gap);
          if (rd_valid[u]) begin
            check_output("rd_valid_width", rv_prev[u], 0);
            check_output("rd_expected", 32'(exp_rd.size() != 0), 1);
            if (exp_rd.size() != 0) check_output("rd_data", rd_data[u], exp_rd.pop_front());
          end
        end
        if (rd_valid[u]) rv_cnt[u]++;
        rv_prev[u] = rd_valid[u];
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      slave_step();
      monitor_step();
    end
  end

  task automatic wait_accept(input int u);
    int c0;
    c0 = acc_cnt[u];
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (acc_cnt[u] != c0) break;
    end
    check_output("accept_seen", 32'(acc_cnt[u] != c0), 1);
  endtask

  task automatic wait_idle(input int u);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (!busy[u]) break;
    end
    check_output("idle_reached", busy[u], 0);
  endtask

  // Reference model: tracks the slave's address registers and RAM from request values alone.
  task automatic expect_req(input int u, input logic [1:0] op, input logic [7:0] d);
    frame_t fe;
    fe.unit    = u;
    fe.low_len = (op == 2'b11) ? 20 + rdl(u) : 12;
    fe.mosi    = {1'b0, op[1], op, d};
    fe.is_read = (op == 2'b11);
    exp_frames.push_back(fe);
    case (op)
      2'b00: ref_addr[u] = d;
      2'b01: ref_mem[u][ref_addr[u]] = d;
      2'b10: ref_raddr[u] = d;
      default: exp_rd.push_back(ref_mem[u][ref_raddr[u]]);
    endcase
  endtask

  task automatic apply_stimulus(input int u, input logic [1:0] op, input logic [7:0] d);
    expect_req(u, op, d);
    req_op[u]    = op;
    req_data[u]  = d;
    req_valid[u] = 1'b1;
    wait_accept(u);
    req_valid[u] = 1'b0;
  endtask

  task automatic reset_unit(input int u);
    rst_n[u] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_ss_n", SS_n[u], 1);
    check_output("reset_mosi", MOSI[u], 0);
    check_output("reset_busy", busy[u], 0);
    check_output("reset_req_ready", req_ready[u], 1);
    check_output("reset_rd_valid", rd_valid[u], 0);
    check_output("reset_rd_data", rd_data[u], 8'h00);
    rst_n[u] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic abort_test(input int u);
    int rv0;
    apply_stimulus(u, 2'b00, 8'h20);
    apply_stimulus(u, 2'b01, 8'hC3);
    apply_stimulus(u, 2'b10, 8'h20);
    apply_stimulus(u, 2'b11, 8'h00);
    for (int i = 0; i < 100; i++) begin
      if (sk[u] == 12 + rdl(u) + 4) break;
      @(posedge clk);
      #1;
    end
    check_output("abort_reached_recv_bit4", sk[u], 12 + rdl(u) + 4);
    rst_n[u] = 1'b0;
    exp_frames.delete();
    exp_rd.delete();
    rv0 = rv_cnt[u];
    @(posedge clk);
    #1;
    check_output("abort_ss_n", SS_n[u], 1);
    check_output("abort_busy", busy[u], 0);
    check_output("abort_req_ready", req_ready[u], 1);
    check_output("abort_rd_valid", rd_valid[u], 0);
    rst_n[u] = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check_output("abort_no_rd_pulse", rv_cnt[u] - rv0, 0);
    check_output("abort_rd_data_kept", rd_data[u], 8'h00);
  endtask

  task automatic back_to_back(input int u, input logic [7:0] d1, input logic [7:0] d2);
    int t1;
    expect_req(u, 2'b01, d1);
    expect_req(u, 2'b10, d2);
    req_op[u]    = 2'b01;
    req_data[u]  = d1;
    req_valid[u] = 1'b1;
    wait_accept(u);
    t1 = acc_cycle[u];
    req_op[u]   = 2'b10;
    req_data[u] = d2;
    wait_accept(u);
    req_valid[u] = 1'b0;
    check_output("b2b_accept_spacing", acc_cycle[u] - t1, 12 + gapc(u) + 1);
  endtask

  task automatic run_unit(input int u);
    logic [1:0] op;
    logic [7:0] d;
    reset_unit(u);
    abort_test(u);

    apply_stimulus(u, 2'b00, 8'hA5);
    wait_idle(u);
    check_output("ready_after_write_addr", req_ready[u], 1);

    apply_stimulus(u, 2'b01, 8'h3C);
    apply_stimulus(u, 2'b10, 8'hA5);
    apply_stimulus(u, 2'b11, 8'h00);
    wait_idle(u);
    check_output("read_3c_direct", rd_data[u], 8'h3C);

    back_to_back(u, 8'h77, 8'h42);
    wait_idle(u);

    apply_stimulus(u, 2'b00, 8'h10);
    apply_stimulus(u, 2'b01, 8'h5A);
    apply_stimulus(u, 2'b10, 8'h10);
    apply_stimulus(u, 2'b11, 8'h00);
    wait_idle(u);
    check_output("ram_roundtrip_5a", rd_data[u], 8'h5A);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      d  = (op[0] == 1'b0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      apply_stimulus(u, op, d);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_idle(u);
    repeat (5) @(posedge clk);
    #1;
    check_output("frames_drained", exp_frames.size(), 0);
    check_output("reads_drained", exp_rd.size(), 0);
    rst_n[u] = 1'b0;
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst_n[u]     = 1'b0;
      req_valid[u] = 1'b0;
      req_op[u]    = 2'b00;
      req_data[u]  = 8'h00;
      ref_addr[u]  = 8'h00;
      ref_raddr[u] = 8'h00;
      s_addr[u]    = 8'h00;
      s_raddr[u]   = 8'h00;
      s_byte[u]    = 8'h00;
      sh[u]        = '0;
      sk[u]        = 0;
      rv_cnt[u]    = 0;
      for (int a = 0; a < 256; a++) begin
        ref_mem[u][a] = 8'h00;
        sram[u][a]    = 8'h00;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] unit 0: RD_LAT=2 GAP_CYC=1");
    run_unit(0);
    $display("[TB] unit 1: RD_LAT=4 GAP_CYC=3");
    run_unit(1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
